// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller sitting between ID/EX decode and the
// control-signal flush mux.
//
// Handles three hazard sources, highest priority first while running:
//   taken branch/jump in EX -> flush IF/ID and ID/EX, pipeline keeps advancing
//   MDU op entering EX      -> freeze PC, IF/ID, ID/EX for MDU_LAT-1 cycles
//   load-use on rs/rt       -> hold PC and IF/ID, inject one bubble into ID/EX
//
// Parameters:
//   MDU_LAT  total EX-stage cycles of an MDU op (>= 3 for an exact stall length)
//   CW       MDU counter width, 2**CW > MDU_LAT
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   id_rs, id_rt           source fields of the instruction in ID
//   id_uses_rt             ID instruction reads rt
//   ex_rt, ex_memread      destination / load flag of the instruction in EX
//   ex_branch_taken        control transfer resolved taken in EX
//   ex_mdu_start           MDU op entered EX this cycle
//   pc_we, ifid_we, idex_we  pipeline write enables
//   ifid_flush, idex_flush   zero IF/ID instruction / insert ID/EX bubble
//   mdu_busy               MDU stall in progress
//
// Optional feature, enabled by defining HAZ_STATS_EN:
//   stall_cycles, bubble_cycles  saturating 32-bit counters of cycles with
//                                pc_we=0 and idex_flush=1 respectively
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CW      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rt,
    input  logic       ex_memread,
    input  logic       ex_branch_taken,
    input  logic       ex_mdu_start,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic       idex_we,
    output logic       idex_flush,
    output logic       mdu_busy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_cycles
`endif
);

    localparam logic [0:0] StRun     = 1'b0;
    localparam logic [0:0] StMduBusy = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [CW-1:0] mdu_cnt_dec;
    logic          load_use;

    // $zero is never a real dependency.
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Counter stops at zero, never wraps.
    assign mdu_cnt_dec = (mdu_cnt_q != '0) ? mdu_cnt_q - CW'(1) : '0;

    always_comb begin
        state_d    = state_q;
        mdu_cnt_d  = mdu_cnt_q;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_busy   = 1'b0;

        case (state_q)
            StRun: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_mdu_start) begin
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    idex_we   = 1'b0;
                    mdu_busy  = 1'b1;
                    state_d   = StMduBusy;
                    mdu_cnt_d = CW'(MDU_LAT - 2);
                end else if (load_use) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            StMduBusy: begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                idex_we   = 1'b0;
                mdu_busy  = 1'b1;
                mdu_cnt_d = mdu_cnt_dec;
                // Leave as the count reaches zero so the start cycle plus the
                // MDU_LAT-2 busy cycles give a stall of MDU_LAT-1 cycles.
                if (mdu_cnt_dec == '0) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d   = StRun;
                mdu_cnt_d = '0;
            end
        endcase

        if (reset) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            mdu_busy   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRun;
            mdu_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else begin
            if (!pc_we && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (idex_flush && (bubble_cycles != 32'hFFFF_FFFF)) begin
                bubble_cycles <= bubble_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_LAT=4). Each step drives inputs on the
// falling edge, pushes the expected output vector to a scoreboard queue and
// pops/compares it 1 ns later. Vector order:
// {pc_we, ifid_we, idex_we, ifid_flush, idex_flush, mdu_busy}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, ex_branch_taken, ex_mdu_start;
    logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush, mdu_busy;
`ifdef HAZ_STATS_EN
    logic [31:0] stall_cycles, bubble_cycles;
    logic [31:0] stall_exp, bubble_exp;
`endif

    int tests = 0;
    int fails = 0;
    bit model_valid = 1'b0;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    localparam logic [5:0] VRst  = 6'b000110;
    localparam logic [5:0] VNorm = 6'b111000;
    localparam logic [5:0] VLu   = 6'b001010;
    localparam logic [5:0] VBr   = 6'b111110;
    localparam logic [5:0] VMdu  = 6'b000001;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MDU_LAT(4),
        .CW     (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_rt          (ex_rt),
        .ex_memread     (ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start   (ex_mdu_start),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .idex_we        (idex_we),
        .idex_flush     (idex_flush),
        .mdu_busy       (mdu_busy)
`ifdef HAZ_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .bubble_cycles  (bubble_cycles)
`endif
    );

    task automatic check_out();
        logic [5:0] exp_v;
        logic [5:0] obs_v;
        string      tag;
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        obs_v = {pc_we, ifid_we, idex_we, ifid_flush, idex_flush, mdu_busy};
        tests++;
        assert (obs_v === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
        end
`ifdef HAZ_STATS_EN
        if (model_valid) begin
            tests++;
            assert (stall_cycles === stall_exp) else begin
                fails++;
                $error("FAIL %s/stall_cycles: observed %0d expected %0d", tag, stall_cycles,
                       stall_exp);
            end
            tests++;
            assert (bubble_cycles === bubble_exp) else begin
                fails++;
                $error("FAIL %s/bubble_cycles: observed %0d expected %0d", tag, bubble_cycles,
                       bubble_exp);
            end
        end
`endif
    endtask

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] xrt, input logic mr,
                        input logic br, input logic ms, input logic [5:0] exp_v,
                        input string tag);
        @(negedge clk);
        reset           = rst;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = urt;
        ex_rt           = xrt;
        ex_memread      = mr;
        ex_branch_taken = br;
        ex_mdu_start    = ms;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        #1;
        check_out();
`ifdef HAZ_STATS_EN
        // Model of the counter update at the coming rising edge.
        if (rst) begin
            stall_exp  = 32'd0;
            bubble_exp = 32'd0;
        end else begin
            if (!exp_v[5]) stall_exp = stall_exp + 32'd1;
            if (exp_v[1])  bubble_exp = bubble_exp + 32'd1;
        end
`endif
        if (rst) model_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        {id_rs, id_rt, ex_rt} = '0;
        {id_uses_rt, ex_memread, ex_branch_taken, ex_mdu_start} = '0;

        // Reset and release
        step(1, 0, 0, 0, 0, 0, 0, 0, VRst,  "reset_c1");
        step(1, 0, 0, 0, 0, 0, 0, 0, VRst,  "reset_c2");
        step(0, 0, 0, 0, 0, 0, 0, 0, VNorm, "post_reset");

        // Load-use on rs, then recovery; $zero never stalls
        step(0, 8, 0, 0, 8, 1, 0, 0, VLu,   "lu_rs");
        step(0, 8, 0, 0, 8, 0, 0, 0, VNorm, "lu_rs_done");
        step(0, 0, 0, 0, 0, 1, 0, 0, VNorm, "lu_zero");

        // Load-use on rt depends on id_uses_rt
        step(0, 1, 9, 0, 9, 1, 0, 0, VNorm, "lu_rt_unused");
        step(0, 1, 9, 1, 9, 1, 0, 0, VLu,   "lu_rt_used");
        step(0, 1, 9, 1, 9, 0, 0, 0, VNorm, "lu_rt_done");

        // Branch beats load-use; branch beats MDU start and stays in RUN
        step(0, 8, 0, 0, 8, 1, 1, 0, VBr,   "br_over_lu");
        step(0, 0, 0, 0, 0, 0, 1, 1, VBr,   "br_over_mdu");
        step(0, 0, 0, 0, 0, 0, 0, 0, VNorm, "br_over_mdu_after");

        // MDU stall: 3 stalled cycles, branch/LU ignored while busy
        step(0, 8, 0, 0, 8, 1, 0, 1, VMdu,  "mdu_start_over_lu");
        step(0, 0, 0, 0, 0, 0, 1, 0, VMdu,  "mdu_busy1_br");
        step(0, 8, 0, 0, 8, 1, 0, 1, VMdu,  "mdu_busy2_lu_ms");
        step(0, 0, 0, 0, 0, 0, 0, 0, VNorm, "mdu_resume");
        step(0, 0, 0, 0, 0, 0, 0, 0, VNorm, "mdu_resume2");

        // Reset in the 2nd busy cycle aborts the stall
        step(0, 0, 0, 0, 0, 0, 0, 1, VMdu,  "abort_start");
        step(0, 0, 0, 0, 0, 0, 0, 0, VMdu,  "abort_busy1");
        step(1, 0, 0, 0, 0, 0, 0, 0, VRst,  "abort_reset");
        step(0, 0, 0, 0, 0, 0, 0, 0, VNorm, "abort_run");

        // Back-to-back MDU ops after an abort
        step(0, 0, 0, 0, 0, 0, 0, 1, VMdu,  "mdu2_start");
        step(0, 0, 0, 0, 0, 0, 0, 0, VMdu,  "mdu2_busy1");
        step(0, 0, 0, 0, 0, 0, 0, 0, VMdu,  "mdu2_busy2");
        step(0, 0, 0, 0, 0, 0, 0, 1, VMdu,  "mdu3_start");
        step(0, 0, 0, 0, 0, 0, 0, 0, VMdu,  "mdu3_busy1");
        step(0, 0, 0, 0, 0, 0, 0, 0, VMdu,  "mdu3_busy2");
        step(0, 0, 0, 0, 0, 0, 0, 0, VNorm, "mdu3_resume");
        step(0, 5, 5, 1, 5, 1, 0, 0, VLu,   "lu_rs_rt_both");
        step(0, 5, 5, 1, 5, 0, 0, 0, VNorm, "final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
